// File: rtl/rename_register_file.sv
// ============================================================================
//  Module   : rename_register_file
//  Purpose  : Architectural register file with per-register rename tags and
//             same-cycle commit bypass on every read port.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

`ifndef ROB_WIDTH_BIT
`define ROB_WIDTH_BIT 4
`endif

module rename_register_file #(
  parameter int XLEN = 32,
  parameter int NREG = 32,
  parameter int TAGW = `ROB_WIDTH_BIT,
  parameter int NRD  = 2,
  localparam int REGW = $clog2(NREG)
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic                 rdy_in,
  input  logic                 flush_in,
  input  logic                 rename_en,
  input  logic [REGW-1:0]      rename_reg,
  input  logic [TAGW-1:0]      rename_tag,
  input  logic                 commit_en,
  input  logic [REGW-1:0]      commit_reg,
  input  logic [TAGW-1:0]      commit_tag,
  input  logic [XLEN-1:0]      commit_val,
  input  logic [NRD*REGW-1:0]  rd_id,
  output logic [NRD*XLEN-1:0]  rd_val,
  output logic [NRD-1:0]       rd_has_dep,
  output logic [NRD*TAGW-1:0]  rd_dep
);

  logic [XLEN-1:0] w_value [NREG];
  logic [TAGW-1:0] w_dep   [NREG];
  logic [NREG-1:0] w_has_dep;

  for (genvar g = 0; g < NREG; g++) begin : g_reg
    if (g == 0) begin : g_zero
      assign w_value[g]   = '0;
      assign w_dep[g]     = '0;
      assign w_has_dep[g] = 1'b0;
    end else begin : g_live
      localparam logic [REGW-1:0] c_idx = REGW'(g);

      logic [XLEN-1:0] r_value;
      logic [TAGW-1:0] r_dep;
      logic            r_has_dep;
      logic            w_commit_hit;
      logic            w_rename_hit;

      assign w_commit_hit = commit_en && (commit_reg == c_idx);
      assign w_rename_hit = rename_en && !flush_in && (rename_reg == c_idx);

      // Priority on has_dep: flush, then a new rename, then a tag-matching commit.
      always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
          r_value   <= '0;
          r_dep     <= '0;
          r_has_dep <= 1'b0;
        end else if (rdy_in) begin
          if (w_commit_hit) begin
            r_value <= commit_val;
          end
          if (flush_in) begin
            r_has_dep <= 1'b0;
          end else if (w_rename_hit) begin
            r_has_dep <= 1'b1;
            r_dep     <= rename_tag;
          end else if (w_commit_hit && r_has_dep && (r_dep == commit_tag)) begin
            r_has_dep <= 1'b0;
          end
        end
      end

      assign w_value[g]   = r_value;
      assign w_dep[g]     = r_dep;
      assign w_has_dep[g] = r_has_dep;
    end
  end

  for (genvar p = 0; p < NRD; p++) begin : g_rd
    logic [REGW-1:0] w_id;
    logic            w_bypass;

    assign w_id = rd_id[p*REGW +: REGW];

    // Only a commit that would actually retire the pending producer is forwarded.
    assign w_bypass = rst_in && rdy_in && commit_en && (commit_reg == w_id) &&
                      (w_id != '0) && w_has_dep[w_id] && (w_dep[w_id] == commit_tag);

    assign rd_val[p*XLEN +: XLEN] = w_bypass ? commit_val : w_value[w_id];
    assign rd_has_dep[p]          = w_has_dep[w_id] && !w_bypass;
    assign rd_dep[p*TAGW +: TAGW] = w_dep[w_id];
  end

endmodule

`default_nettype wire
